// File: rtl/flit_mux2.sv
`default_nettype none
// ============================================================================
// Module   : flit_mux2
// Brief    : Two-input registered flit multiplexer with one-hot port select.
//            Optional packet lock (HEAD..TAIL) under FLIT_MUX_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module flit_mux2 #(
    parameter int DATA_W = 64,
    parameter int VCH_W  = 1,
    parameter int PORT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [PORT_W-1:0] sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    logic              w_pick0;
    logic              w_pick1;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic [VCH_W-1:0]  w_vch;

    logic [DATA_W-1:0] r_odata;
    logic              r_ovalid;
    logic [VCH_W-1:0]  r_ovch;

`ifdef FLIT_MUX_PKT_LOCK_EN
    localparam logic [1:0] c_TYPE_HEAD = 2'b01;
    localparam logic [1:0] c_TYPE_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] w_ftype;

    assign w_ftype = w_data[DATA_W-1 -: 2];

    // While locked, the owning input is forwarded regardless of sel.
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        case (r_state)
            ST_LOCK0: w_pick0 = 1'b1;
            ST_LOCK1: w_pick1 = 1'b1;
            default: begin
                w_pick0 = (sel[1:0] == 2'b01);
                w_pick1 = (sel[1:0] == 2'b10);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && (w_ftype == c_TYPE_HEAD))
                        r_state <= w_pick0 ? ST_LOCK0 : ST_LOCK1;
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (w_valid && (w_ftype == c_TYPE_TAIL))
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign w_pick0 = (sel[1:0] == 2'b01);
    assign w_pick1 = (sel[1:0] == 2'b10);
`endif

    // Only sel[1:0] is decoded; the remaining port bits are don't-care here.
    generate
        if (PORT_W > 2) begin : g_sel_upper
            logic w_unused_sel;
            assign w_unused_sel = ^sel[PORT_W-1:2];
        end
    endgenerate

    // Data and VC pass through even when the selected valid is low.
    always_comb begin
        w_data  = '0;
        w_valid = 1'b0;
        w_vch   = '0;
        if (w_pick0) begin
            w_data  = idata_0;
            w_valid = ivalid_0;
            w_vch   = ivch_0;
        end else if (w_pick1) begin
            w_data  = idata_1;
            w_valid = ivalid_1;
            w_vch   = ivch_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_odata  <= '0;
            r_ovalid <= 1'b0;
            r_ovch   <= '0;
        end else begin
            r_odata  <= w_data;
            r_ovalid <= w_valid;
            r_ovch   <= w_vch;
        end
    end

    assign odata  = r_odata;
    assign ovalid = r_ovalid;
    assign ovch   = r_ovch;

endmodule
`default_nettype wire

// File: tb/tb_flit_mux2.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_mux2
// Brief    : Randomized self-checking bench for flit_mux2 with a behavioural
//            reference model (packet-lock rules enabled by FLIT_MUX_PKT_LOCK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_mux2;

    localparam int DATA_W = 64;
    localparam int VCH_W  = 1;
    localparam int PORT_W = 5;

    localparam logic [1:0] c_NONE = 2'b00;
    localparam logic [1:0] c_HEAD = 2'b01;
    localparam logic [1:0] c_TAIL = 2'b10;
    localparam logic [1:0] c_DATA = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] idata_0, idata_1;
    logic              ivalid_0, ivalid_1;
    logic [VCH_W-1:0]  ivch_0, ivch_1;
    logic [PORT_W-1:0] sel;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic [VCH_W-1:0]  ovch;

    int checks = 0;
    int errors = 0;

    // Reference model: which input currently owns the output (-1 = none).
    int                m_lock = -1;
    logic [DATA_W-1:0] e_data;
    logic              e_valid;
    logic [VCH_W-1:0]  e_vch;

    flit_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .PORT_W(PORT_W)) dut (
        .clk(clk), .rst(rst),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel),
        .odata(odata), .ovalid(ovalid), .ovch(ovch)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_flit(input logic [1:0] t);
        logic [DATA_W-1:0] f;
        f = {$urandom(), $urandom()};
        f[DATA_W-1 -: 2] = t;
        return f;
    endfunction

    // Predict the outputs for the current inputs, then advance one edge.
    task automatic tick();
        int src;
        if (rst) begin
            e_data = '0; e_valid = 1'b0; e_vch = '0; m_lock = -1;
        end else begin
            if (m_lock >= 0)            src = m_lock;
            else if (sel[1:0] == 2'b01) src = 0;
            else if (sel[1:0] == 2'b10) src = 1;
            else                        src = -1;
            if (src == 0) begin
                e_data = idata_0; e_valid = ivalid_0; e_vch = ivch_0;
            end else if (src == 1) begin
                e_data = idata_1; e_valid = ivalid_1; e_vch = ivch_1;
            end else begin
                e_data = '0; e_valid = 1'b0; e_vch = '0;
            end
`ifdef FLIT_MUX_PKT_LOCK_EN
            if (e_valid) begin
                if (m_lock < 0 && e_data[DATA_W-1 -: 2] == c_HEAD) m_lock = src;
                else if (m_lock >= 0 && e_data[DATA_W-1 -: 2] == c_TAIL) m_lock = -1;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 5'b00010;
        idata_1 = '1; ivalid_1 = 1'b1; ivch_1 = 1'b1;
        idata_0 = mk_flit(c_DATA); ivalid_0 = 1'b1; ivch_0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (odata !== '0 || ovalid !== 1'b0 || ovch !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h/%b/%h want 0/0/0", i, odata, ovalid, ovch);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (odata !== {DATA_W{1'b1}} || ovalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got %h/%b want all-ones/1", odata, ovalid);
        end
    endtask

    task automatic test_select1();
        logic [DATA_W-1:0] drv;
        sel = 5'b00010; ivch_1 = 1'b1; ivalid_1 = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 0)       drv = {c_HEAD, 62'h4};
            else if (i == 21) drv = mk_flit(c_TAIL);
            else              drv = mk_flit(c_DATA);
            idata_1 = drv;
            idata_0 = mk_flit(2'($urandom_range(3))); ivalid_0 = 1'($urandom); ivch_0 = 1'($urandom);
            tick();
            checks++;
            if (odata !== drv || ovch !== 1'b1 || ovalid !== 1'b1 ||
                odata !== e_data || ovalid !== e_valid || ovch !== e_vch) begin
                errors++;
                $display("FAIL select1[%0d]: got %h/%b/%h want %h/1/1", i, odata, ovalid, ovch, drv);
            end
        end
    endtask

    task automatic test_invalid_sel();
        logic [PORT_W-1:0] pats [3];
        pats[0] = 5'b00000; pats[1] = 5'b00011; pats[2] = 5'b11101;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) begin
                sel = pats[p];
                idata_0 = mk_flit(c_DATA); ivalid_0 = 1'b1; ivch_0 = 1'($urandom);
                idata_1 = mk_flit(c_DATA); ivalid_1 = 1'b1; ivch_1 = 1'($urandom);
                tick();
                checks++;
                if (odata !== e_data || ovalid !== e_valid || ovch !== e_vch) begin
                    errors++;
                    $display("FAIL invalid_sel[%b,%0d]: got %h/%b/%h want %h/%b/%h",
                             pats[p], i, odata, ovalid, ovch, e_data, e_valid, e_vch);
                end
            end
        end
    endtask

    task automatic test_transparent();
        logic [DATA_W-1:0] drv;
        sel = 5'b00010; ivalid_1 = 1'b0; ivch_1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drv = (i % 2 == 0) ? 64'h0000_0000_0000_7FF0 : 64'h0000_0000_0000_00FF;
            idata_1 = drv;
            idata_0 = mk_flit(c_DATA); ivalid_0 = 1'b1;
            tick();
            checks++;
            if (odata !== drv || ovalid !== 1'b0 || odata !== e_data) begin
                errors++;
                $display("FAIL transparent[%0d]: got %h/%b want %h/0", i, odata, ovalid, drv);
            end
        end
    endtask

    task automatic test_switch();
        logic [DATA_W-1:0] d1;
        ivalid_0 = 1'b1; ivalid_1 = 1'b1; ivch_0 = 1'b0; ivch_1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            sel = (i < 5) ? 5'b00001 : 5'b00010;
            if (i == 0)       idata_0 = mk_flit(c_HEAD);
            else if (i == 9)  idata_0 = mk_flit(c_TAIL);
            else              idata_0 = mk_flit(c_DATA);
            d1 = mk_flit(c_DATA);
            idata_1 = d1;
            tick();
            checks++;
            if (odata !== e_data || ovalid !== e_valid || ovch !== e_vch) begin
                errors++;
                $display("FAIL switch[%0d]: got %h/%b/%h want %h/%b/%h",
                         i, odata, ovalid, ovch, e_data, e_valid, e_vch);
            end
`ifndef FLIT_MUX_PKT_LOCK_EN
            if (i == 5) begin
                checks++;
                if (odata !== d1 || ovch !== 1'b1) begin
                    errors++;
                    $display("FAIL switch_edge: got %h/%h want %h/1", odata, ovch, d1);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d0;
        sel = 5'b00010; idata_1 = mk_flit(c_HEAD); ivalid_1 = 1'b1;
        tick();
        idata_1 = mk_flit(c_DATA);
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (odata !== '0 || ovalid !== 1'b0 || ovch !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h/%b/%h want 0/0/0", odata, ovalid, ovch);
        end
        rst = 1'b0; sel = 5'b00001;
        d0 = mk_flit(c_DATA); idata_0 = d0; ivalid_0 = 1'b1; ivch_0 = 1'b1;
        tick();
        checks++;
        if (odata !== d0 || ovalid !== 1'b1 || ovch !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: got %h/%b/%h want %h/1/1", odata, ovalid, ovch, d0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(99) < 4);
            sel = PORT_W'($urandom);
            idata_0 = mk_flit(2'($urandom_range(3))); ivalid_0 = 1'($urandom); ivch_0 = 1'($urandom);
            idata_1 = mk_flit(2'($urandom_range(3))); ivalid_1 = 1'($urandom); ivch_1 = 1'($urandom);
            tick();
            checks++;
            if (odata !== e_data || ovalid !== e_valid || ovch !== e_vch) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%b/%h want %h/%b/%h",
                         i, odata, ovalid, ovch, e_data, e_valid, e_vch);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = '0;
        idata_0 = '0; ivalid_0 = 1'b0; ivch_0 = '0;
        idata_1 = '0; ivalid_1 = 1'b0; ivch_1 = '0;
        e_data = '0; e_valid = 1'b0; e_vch = '0;
        @(negedge clk);
        test_reset();
        test_select1();
        test_invalid_sel();
        test_transparent();
        test_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
